dsp_mac_array: RTL

Parametrised pipelined multiply-accumulate slice that computes the dot product of a fixed-length stream of term pairs. It has an optional per-term pre-adder and per-term add/subtract accumulation. It succeeds the single-shot DSP slice with configurable operand, accumulator and pipeline widths, automatic term framing, sticky carry/borrow reporting and valid/ready flow control with full-pipeline stall. It sits between the sample front end and the filter/correlator back end.

---
 rtl/dsp_mac_array.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/dsp_mac_array.sv
// Pipelined unsigned MAC slice: DOT_LEN-term dot product with optional pre-adder, per-term
// add/subtract, sticky carry and full-pipeline stall. Optional clamping via DSP_MAC_SAT_EN.
module dsp_mac_array #(
  parameter int A_WIDTH = 18,
  parameter int B_WIDTH = 18,
  parameter int P_WIDTH = 48,
  parameter int MREG    = 1,
  parameter int DOT_LEN = 4
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] A,
  input  logic [B_WIDTH-1:0] B,
  input  logic [B_WIDTH-1:0] D,
  input  logic [2:0]         opmode,
  output logic [P_WIDTH-1:0] P,
  output logic               P_valid,
  input  logic               P_ready,
  output logic               P_carry,
  output logic               busy
);
  localparam int M_WIDTH = A_WIDTH + B_WIDTH;
  localparam int C_WIDTH = (DOT_LEN > 1) ? $clog2(DOT_LEN) : 1;
  localparam logic [C_WIDTH-1:0] LAST_CNT = C_WIDTH'(DOT_LEN - 1);

  logic               stall;
  logic               accept;

  logic               v1_q, v1_d;
  logic               sub1_q, sub1_d;
  logic [A_WIDTH-1:0] a1_q, a1_d;
  logic [B_WIDTH-1:0] bsel1_q, bsel1_d;
  logic [M_WIDTH-1:0] prod1;

  logic               vm;
  logic               subm;
  logic [M_WIDTH-1:0] prodm;

  logic [C_WIDTH-1:0] cnt_q, cnt_d;
  logic [P_WIDTH-1:0] acc_q, acc_d;
  logic               sticky_q, sticky_d;
  logic [P_WIDTH-1:0] p_q, p_d;
  logic               carry_q, carry_d;
  logic               pv_q, pv_d;

  logic [P_WIDTH-1:0] prod_ext;
  logic [P_WIDTH-1:0] base;
  logic [P_WIDTH:0]   raw;
  logic [P_WIDTH-1:0] sum;
  logic               cflag;
  logic               fire;
  logic               last;

  assign stall    = pv_q && !P_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;

  always_comb begin
    v1_d    = v1_q;
    sub1_d  = sub1_q;
    a1_d    = a1_q;
    bsel1_d = bsel1_q;
    if (!stall) begin
      v1_d = accept;
      if (accept) begin
        a1_d   = A;
        sub1_d = opmode[2];
        if (!opmode[0])     bsel1_d = B;
        else if (opmode[1]) bsel1_d = D - B;
        else                bsel1_d = D + B;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      v1_q    <= 1'b0;
      sub1_q  <= 1'b0;
      a1_q    <= '0;
      bsel1_q <= '0;
    end else begin
      v1_q    <= v1_d;
      sub1_q  <= sub1_d;
      a1_q    <= a1_d;
      bsel1_q <= bsel1_d;
    end
  end

  assign prod1 = {{B_WIDTH{1'b0}}, a1_q} * {{A_WIDTH{1'b0}}, bsel1_q};

  generate
    if (MREG != 0) begin : g_mreg
      logic               vm_q, vm_d;
      logic               subm_q, subm_d;
      logic [M_WIDTH-1:0] prodm_q, prodm_d;

      always_comb begin
        vm_d    = vm_q;
        subm_d  = subm_q;
        prodm_d = prodm_q;
        if (!stall) begin
          vm_d    = v1_q;
          subm_d  = sub1_q;
          prodm_d = prod1;
        end
      end

      always_ff @(posedge clk) begin
        if (RST) begin
          vm_q    <= 1'b0;
          subm_q  <= 1'b0;
          prodm_q <= '0;
        end else begin
          vm_q    <= vm_d;
          subm_q  <= subm_d;
          prodm_q <= prodm_d;
        end
      end

      assign vm    = vm_q;
      assign subm  = subm_q;
      assign prodm = prodm_q;
    end else begin : g_nomreg
      assign vm    = v1_q;
      assign subm  = sub1_q;
      assign prodm = prod1;
    end
  endgenerate

  // The extra top bit of raw is the carry on add and the borrow on subtract.
  always_comb begin
    prod_ext = P_WIDTH'(prodm);
    base     = (cnt_q == '0) ? '0 : acc_q;
    if (subm) raw = {1'b0, base} - {1'b0, prod_ext};
    else      raw = {1'b0, base} + {1'b0, prod_ext};
    cflag = raw[P_WIDTH];
    sum   = raw[P_WIDTH-1:0];
`ifdef DSP_MAC_SAT_EN
    if (cflag) sum = subm ? '0 : '1;
`endif
  end

  assign fire = vm && !stall;
  assign last = (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    sticky_d = sticky_q;
    p_d      = p_q;
    carry_d  = carry_q;
    pv_d     = pv_q;
    if (pv_q && P_ready) pv_d = 1'b0;
    if (fire) begin
      sticky_d = ((cnt_q == '0) ? 1'b0 : sticky_q) | cflag;
      if (last) begin
        p_d     = sum;
        carry_d = sticky_d;
        pv_d    = 1'b1;
        cnt_d   = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + C_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      sticky_q <= 1'b0;
      p_q      <= '0;
      carry_q  <= 1'b0;
      pv_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
      p_q      <= p_d;
      carry_q  <= carry_d;
      pv_q     <= pv_d;
    end
  end

  assign P       = p_q;
  assign P_valid = pv_q;
  assign P_carry = carry_q;
  assign busy    = v1_q || vm || (cnt_q != '0);

endmodule
